// File: rtl/round_scoreboard_pkg.sv
// Shared match-flow package (game_pkg). It holds the match FSM state encoding,
// the round-result encoding, the score counter width and a saturating
// increment helper. round_scoreboard and its interface import it.
package game_pkg;

  localparam int unsigned WIN_CNT_W = 4;

  // Same encoding as the match FSM.
  typedef enum logic [2:0] {
    GS_START               = 3'd0,
    GS_SET_TANK_BA         = 3'd1,
    GS_SET_BULLET_COOLDOWN = 3'd2,
    GS_PLAY                = 3'd3,
    GS_CHECK               = 3'd4,
    GS_END                 = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    RR_NONE = 2'b00,
    RR_P1   = 2'b01,
    RR_P2   = 2'b10,
    RR_DRAW = 2'b11
  } round_result_t;

  // Round-credit FSM of the scoreboard.
  typedef enum logic {
    SB_ARMED  = 1'b0,
    SB_SCORED = 1'b1
  } sb_state_t;

  function automatic logic [WIN_CNT_W-1:0] sat_inc(input logic [WIN_CNT_W-1:0] v);
    return (v == '1) ? v : v + WIN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/round_scoreboard_if.sv
// Match-flow <-> scoreboard interface.
//   master (match FSM side): drives game_state, tank_dead_1/2, btn_up/down;
//                            reads p1_score, p2_score, wins_need, round_winner,
//                            round_done, match_winner.
//   slave  (round_scoreboard): the reverse directions.
// game_state is a plain 3-bit vector so that the illegal codes 6/7 can appear.
interface round_scoreboard_if;
  import game_pkg::*;

  logic [2:0]           game_state;
  logic                 tank_dead_1;
  logic                 tank_dead_2;
  logic                 btn_up;
  logic                 btn_down;
  logic [WIN_CNT_W-1:0] p1_score;
  logic [WIN_CNT_W-1:0] p2_score;
  logic [WIN_CNT_W-1:0] wins_need;
  logic [1:0]           round_winner;
  logic                 round_done;
  logic [1:0]           match_winner;

  modport master (
    output game_state, tank_dead_1, tank_dead_2, btn_up, btn_down,
    input  p1_score, p2_score, wins_need, round_winner, round_done, match_winner
  );

  modport slave (
    input  game_state, tank_dead_1, tank_dead_2, btn_up, btn_down,
    output p1_score, p2_score, wins_need, round_winner, round_done, match_winner
  );

endinterface

// File: rtl/round_scoreboard_btn_edge.sv
// btn_edge: one-cycle rising-edge detector for a level input already
// synchronous to clk.
//   clk     in  system clock
//   reset   in  asynchronous, active-high; clears the history bit
//   btn_i   in  level input
//   rise_o  out high for the cycle where btn_i is 1 and was 0 on the previous edge
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 1'b0;
    else       hist_q <= btn_i;
  end

  assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/round_scoreboard.sv
// round_scoreboard: scoring end of the match flow. Credits exactly one result
// per round from the tank-death levels, keeps both players' round wins and
// owns the wins-needed setting (adjusted by buttons on the start screen).
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   sb_if  slave modport of round_scoreboard_if (game_state, tank deaths,
//          buttons in; scores, wins_need, round_winner, round_done,
//          match_winner out)
// Parameters: WINS_DEFAULT (reset value of wins_need, 1..WINS_MAX),
//             WINS_MAX (wins_need ceiling, <= 15).
// Build option: define ROUND_SCOREBOARD_DRAW_POINT_EN to award a point to
// both players on a draw; by default a draw awards nothing.
module round_scoreboard
  import game_pkg::*;
#(
  parameter int unsigned WINS_DEFAULT = 3,
  parameter int unsigned WINS_MAX     = 9
) (
  input  logic              clk,
  input  logic              reset,
  round_scoreboard_if.slave sb_if
);

  localparam logic [WIN_CNT_W-1:0] WINS_RST = WIN_CNT_W'(WINS_DEFAULT);
  localparam logic [WIN_CNT_W-1:0] WINS_TOP = WIN_CNT_W'(WINS_MAX);
  localparam logic [WIN_CNT_W-1:0] ONE      = WIN_CNT_W'(1);

  logic up_rise;
  logic dn_rise;

  btn_edge u_up_edge (
    .clk   (clk),
    .reset (reset),
    .btn_i (sb_if.btn_up),
    .rise_o(up_rise)
  );

  btn_edge u_dn_edge (
    .clk   (clk),
    .reset (reset),
    .btn_i (sb_if.btn_down),
    .rise_o(dn_rise)
  );

  sb_state_t            state_q, state_d;
  logic [WIN_CNT_W-1:0] p1_q, p1_d;
  logic [WIN_CNT_W-1:0] p2_q, p2_d;
  logic [WIN_CNT_W-1:0] wins_q, wins_d;
  round_result_t        rw_q, rw_d;
  logic                 rd_q, rd_d;

  logic dead_1;
  logic dead_2;

  assign dead_1 = sb_if.tank_dead_1;
  assign dead_2 = sb_if.tank_dead_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SB_ARMED;
      p1_q    <= '0;
      p2_q    <= '0;
      wins_q  <= WINS_RST;
      rw_q    <= RR_NONE;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      wins_q  <= wins_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
    end
  end

  // Every state other than START and PLAY (SET_*, CHECK, END, 6, 7) holds.
  // The credit is registered on the same edge the match FSM leaves PLAY, so
  // CHECK already sees the new scores.
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    wins_d  = wins_q;
    rw_d    = rw_q;
    rd_d    = 1'b0;

    case (sb_if.game_state)
      GS_START: begin
        state_d = SB_ARMED;
        p1_d    = '0;
        p2_d    = '0;
        rw_d    = RR_NONE;
        if (up_rise && !dn_rise) begin
          if (wins_q < WINS_TOP) wins_d = wins_q + ONE;
        end else if (dn_rise && !up_rise) begin
          if (wins_q > ONE) wins_d = wins_q - ONE;
        end
      end

      GS_PLAY: begin
        if (state_q == SB_ARMED) begin
          if (dead_1 || dead_2) begin
            state_d = SB_SCORED;
            rd_d    = 1'b1;
            if (dead_1 && dead_2) begin
              rw_d = RR_DRAW;
`ifdef ROUND_SCOREBOARD_DRAW_POINT_EN
              p1_d = sat_inc(p1_q);
              p2_d = sat_inc(p2_q);
`else
              p1_d = p1_q;
              p2_d = p2_q;
`endif
            end else if (dead_2) begin
              rw_d = RR_P1;
              p1_d = sat_inc(p1_q);
            end else begin
              rw_d = RR_P2;
              p2_d = sat_inc(p2_q);
            end
          end
        end else if (!dead_1 && !dead_2) begin
          // Re-arm only once the deaths have cleared in PLAY, so a death
          // level still held when PLAY is re-entered is not credited twice.
          state_d = SB_ARMED;
        end
      end

      default: begin
      end
    endcase
  end

  assign sb_if.p1_score     = p1_q;
  assign sb_if.p2_score     = p2_q;
  assign sb_if.wins_need    = wins_q;
  assign sb_if.round_winner = rw_q;
  assign sb_if.round_done   = rd_q;
  assign sb_if.match_winner = {(p2_q >= wins_q), (p1_q >= wins_q)};

endmodule

// File: tb/tb_round_scoreboard.sv
// Directed testbench for round_scoreboard. Expected round results are queued
// when a round's deaths are driven and compared when round_done pulses.
module tb_round_scoreboard;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  round_scoreboard_if bus ();

  round_scoreboard #(
    .WINS_DEFAULT(3),
    .WINS_MAX    (9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb_if(bus)
  );

  typedef struct {
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] rw;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] e_p1, e_p2, e_wins;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] m_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  function automatic logic [1:0] m_mw();
    return {(e_p2 >= e_wins), (e_p1 >= e_wins)};
  endfunction

  task automatic press(input logic up, input logic dn);
    bus.btn_up   = up;
    bus.btn_down = dn;
    tick();
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    tick();
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_p1"}, bus.p1_score, e_p1);
    chk({tag, "_p2"}, bus.p2_score, e_p2);
    chk({tag, "_wins"}, bus.wins_need, e_wins);
    chk({tag, "_mw"}, bus.match_winner, m_mw());
  endtask

  // Drives one round in PLAY; the match FSM moves to CHECK on the credit edge.
  task automatic play_round(input logic d1, input logic d2, input string tag);
    exp_t e;
    logic seen;
    if (d1 && d2) begin
`ifdef ROUND_SCOREBOARD_DRAW_POINT_EN
      e_p1 = m_inc(e_p1);
      e_p2 = m_inc(e_p2);
`endif
      e.rw = 2'b11;
    end else if (d2) begin
      e_p1 = m_inc(e_p1);
      e.rw = 2'b01;
    end else begin
      e_p2 = m_inc(e_p2);
      e.rw = 2'b10;
    end
    e.p1 = e_p1;
    e.p2 = e_p2;
    sbq.push_back(e);

    bus.game_state  = GS_PLAY;
    bus.tank_dead_1 = d1;
    bus.tank_dead_2 = d2;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (bus.round_done === 1'b1) begin
        seen = 1'b1;
        bus.game_state = GS_CHECK;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    e = sbq.pop_front();
    if (seen) begin
      chk({tag, "_p1"}, bus.p1_score, e.p1);
      chk({tag, "_p2"}, bus.p2_score, e.p2);
      chk({tag, "_rw"}, bus.round_winner, e.rw);
      chk({tag, "_mw"}, bus.match_winner, m_mw());
      tick();
      chk({tag, "_done_width"}, bus.round_done, 1'b0);
    end
  endtask

  task automatic rearm();
    bus.tank_dead_1 = 1'b0;
    bus.tank_dead_2 = 1'b0;
    bus.game_state  = GS_PLAY;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset           = 1'b1;
    bus.game_state  = GS_START;
    bus.tank_dead_1 = 1'b0;
    bus.tank_dead_2 = 1'b0;
    bus.btn_up      = 1'b0;
    bus.btn_down    = 1'b0;
    e_p1   = 4'd0;
    e_p2   = 4'd0;
    e_wins = 4'd3;
    repeat (2) tick();
    chk_out("reset");
    chk("reset_rw", bus.round_winner, 2'b00);
    chk("reset_rd", bus.round_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // wins_need adjustment on the start screen
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0);
      e_wins = (e_wins < 4'd9) ? e_wins + 4'd1 : 4'd9;
      chk("wins_up", bus.wins_need, e_wins);
    end
    chk("wins_sat_max", bus.wins_need, 4'd9);
    press(1'b0, 1'b1);
    e_wins = 4'd8;
    press(1'b1, 1'b1);
    chk("wins_both", bus.wins_need, 4'd8);
    bus.btn_up = 1'b1;
    repeat (4) tick();
    bus.btn_up = 1'b0;
    tick();
    e_wins = 4'd9;
    chk("wins_held_once", bus.wins_need, e_wins);
    for (int i = 0; i < 10; i++) begin
      press(1'b0, 1'b1);
      e_wins = (e_wins > 4'd1) ? e_wins - 4'd1 : 4'd1;
      chk("wins_down", bus.wins_need, e_wins);
    end
    chk("wins_sat_min", bus.wins_need, 4'd1);
    bus.game_state = GS_PLAY;
    press(1'b1, 1'b0);
    chk("wins_ignored_play", bus.wins_need, 4'd1);
    bus.game_state = GS_START;
    tick();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    e_wins = 4'd3;
    chk("wins_set3", bus.wins_need, e_wins);

    // held death across PLAY->CHECK->PLAY credits once
    bus.game_state = GS_SET_TANK_BA;
    tick();
    play_round(1'b0, 1'b1, "held");
    bus.game_state = GS_PLAY;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.round_done === 1'b1) pulses++;
    end
    chk("held_extra_pulses", 8'(pulses), 8'd0);
    chk("held_p1", bus.p1_score, 4'd1);
    rearm();
    chk_out("held_after");

    // no credit outside PLAY, including illegal codes
    pulses = 0;
    bus.tank_dead_1 = 1'b1;
    bus.game_state  = GS_SET_BULLET_COOLDOWN;
    repeat (3) begin tick(); if (bus.round_done === 1'b1) pulses++; end
    bus.game_state = GS_CHECK;
    repeat (2) begin tick(); if (bus.round_done === 1'b1) pulses++; end
    bus.game_state = 3'd6;
    repeat (2) begin tick(); if (bus.round_done === 1'b1) pulses++; end
    bus.game_state = 3'd7;
    repeat (2) begin tick(); if (bus.round_done === 1'b1) pulses++; end
    chk("nonplay_pulses", 8'(pulses), 8'd0);
    chk_out("nonplay_hold");
    rearm();

    // draw
    play_round(1'b1, 1'b1, "draw");
    rearm();
    chk_out("draw_after");

    // wins_need=2, P2 takes two rounds
    bus.game_state = GS_START;
    tick();
    e_p1 = 4'd0;
    e_p2 = 4'd0;
    chk_out("start_clear");
    chk("start_clear_rw", bus.round_winner, 2'b00);
    press(1'b0, 1'b1);
    e_wins = 4'd2;
    bus.game_state = GS_SET_TANK_BA;
    tick();
    play_round(1'b1, 1'b0, "p2_r1");
    rearm();
    play_round(1'b1, 1'b0, "p2_r2");
    chk("p2_match_winner", bus.match_winner, 2'b10);

    // END freezes everything
    bus.game_state  = GS_END;
    bus.tank_dead_1 = 1'b0;
    bus.tank_dead_2 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus.btn_up = ~bus.btn_up;
      tick();
      if (bus.round_done === 1'b1) pulses++;
    end
    bus.btn_up = 1'b0;
    chk("end_pulses", 8'(pulses), 8'd0);
    chk_out("end_freeze");
    chk("end_rw", bus.round_winner, 2'b10);

    // score saturation at 15
    bus.game_state = GS_START;
    tick();
    e_p1 = 4'd0;
    e_p2 = 4'd0;
    rearm();
    for (int i = 0; i < 17; i++) begin
      play_round(1'b0, 1'b1, "sat");
      rearm();
    end
    chk("sat_p1", bus.p1_score, 4'd15);

    // asynchronous reset while SCORED with wins_need=5
    bus.game_state = GS_START;
    tick();
    e_p1 = 4'd0;
    e_p2 = 4'd0;
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    e_wins = 4'd5;
    chk("rst_wins5", bus.wins_need, e_wins);
    play_round(1'b0, 1'b1, "pre_rst");
    #2 reset = 1'b1;
    #1;
    e_p1 = 4'd0;
    e_p2 = 4'd0;
    e_wins = 4'd3;
    chk_out("async_rst");
    chk("async_rst_rw", bus.round_winner, 2'b00);
    chk("async_rst_rd", bus.round_done, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    // FSM must be ARMED again: a held death credits straight away
    play_round(1'b0, 1'b1, "post_rst");

    chk("sbq_empty", 8'(sbq.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
